// File: rtl/inbus_rx_fifo_port_if.sv
// Input-bus read port and local producer push port
// for the inbus RX FIFO responder.
interface inbus_rx_fifo_port_if;
  logic [7:0] inbus_addr;
  logic       inbus_re;
  logic [7:0] inbus_data;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       wr_full;

  modport master (
    output inbus_addr,
    output inbus_re,
    output wr_data,
    output wr_en,
    input  inbus_data,
    input  wr_full
  );

  modport slave (
    input  inbus_addr,
    input  inbus_re,
    input  wr_data,
    input  wr_en,
    output inbus_data,
    output wr_full
  );
endinterface

// File: rtl/inbus_rx_fifo_port.sv
// Byte FIFO responder on the 8-bit input bus:
// RXDATA pop, STATUS snapshot, FLAGS read-to-clear.
module inbus_rx_fifo_port #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         DEPTH_LOG2 = 3
) (
  input logic                 clk,
  input logic                 reset,
  inbus_rx_fifo_port_if.slave bus
);

  localparam int         DEPTH_N = 1 << DEPTH_LOG2;
  localparam logic [3:0] DEPTH   = 4'(DEPTH_N);
  localparam logic [7:0] ST_ADDR = BASE_ADDR + 8'd1;
  localparam logic [7:0] FL_ADDR = BASE_ADDR + 8'd2;

  typedef enum logic {
    PH_ADDR = 1'b0,
    PH_DATA = 1'b1
  } phase_e;

  phase_e phase_q, phase_d;

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]            count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [7:0]            rdata_q, rdata_d;
  logic [7:0]            mem_q [DEPTH_N];

  logic rd_act, hit_rx, hit_st, hit_fl;
  logic empty, full;
  logic pop, push, udf_set, ovf_set;

  always_ff @(posedge clk) begin
    if (reset) phase_q <= PH_ADDR;
    else       phase_q <= phase_d;
  end

  always_comb begin
    phase_d = PH_ADDR;
    if (bus.inbus_re && phase_q == PH_ADDR)
      phase_d = PH_DATA;
  end

  assign bus.inbus_data =
    (phase_q == PH_DATA) ? rdata_q : 8'h00;
  assign bus.wr_full = full;

  assign rd_act = bus.inbus_re && (phase_q == PH_ADDR);
  assign hit_rx = rd_act && (bus.inbus_addr == BASE_ADDR);
  assign hit_st = rd_act && (bus.inbus_addr == ST_ADDR);
  assign hit_fl = rd_act && (bus.inbus_addr == FL_ADDR);

  assign empty   = (count_q == 4'd0);
  assign full    = (count_q == DEPTH);
  assign pop     = hit_rx && !empty;
  assign udf_set = hit_rx && empty;
  // A pop on the same edge frees a slot for a push into a full FIFO
  assign push    = bus.wr_en && (!full || pop);
  assign ovf_set = bus.wr_en && full && !pop;

  always_comb begin
    rdata_d = 8'h00;
    unique case (1'b1)
      hit_rx:  rdata_d = empty ? 8'h00 : mem_q[rd_ptr_q];
      hit_st:  rdata_d = {ovf_q, udf_q, full, empty, count_q};
      hit_fl:  rdata_d = {6'b0, udf_q, ovf_q};
      default: rdata_d = 8'h00;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
    count_d  = count_q + 4'(push) - 4'(pop);
    ovf_d    = ovf_set | (ovf_q & ~hit_fl);
    udf_d    = udf_set | (udf_q & ~hit_fl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= bus.wr_data;
  end

endmodule

// File: doc/inbus_rx_fifo_port.md
Name: inbus_rx_fifo_port

Overview:
- Byte-wide responder on the processor's 8-bit input bus. It serves the read accesses issued by the IN-register-indirect instruction unit.
- A local producer pushes bytes into an internal FIFO. The processor pops the FIFO and reads status or sticky error flags through three consecutive inbus addresses.
- Returns 0x00 whenever it is not selected, so several responders can be OR-combined onto inbus_data.

Parameters:
- BASE_ADDR, 8'h10: inbus address of RXDATA. STATUS is at BASE_ADDR+1 and FLAGS at BASE_ADDR+2, computed modulo 256.
- DEPTH_LOG2, 3: FIFO depth is 2**DEPTH_LOG2 bytes. Legal range is 1..3, so the count fits in 4 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- inbus_addr  in  8  read address from the bus initiator.
- inbus_re  in  1  read enable from the bus initiator.
- inbus_data  out  8  registered read data; 0x00 when not driving.
- wr_data  in  8  producer byte.
- wr_en  in  1  producer push strobe, one byte per cycle when high.
- wr_full  out  1  combinational; high when count == DEPTH.

Behaviour:
- Bus protocol (fixed):
  - Every access holds inbus_re high for exactly 2 cycles with a stable address.
  - The initiator samples inbus_data combinationally in the second cycle.
  - Back-to-back accesses keep inbus_re high continuously: 4 cycles means 2 accesses.
- Phase tracker, 1-bit state:
  - PH_ADDR (reset value) goes to PH_DATA when inbus_re=1.
  - PH_DATA goes to PH_ADDR unconditionally.
  - Any cycle with inbus_re=0 forces PH_ADDR.
- Read action: in a PH_ADDR cycle with inbus_re=1 and a hit address, the selected value is registered into inbus_data at the clock edge. Side effects (pop, flag clear) happen on that same edge.
- inbus_data:
  - Holds the registered value only during the PH_DATA cycle.
  - Is 0x00 in every other cycle, including PH_ADDR cycles of back-to-back accesses.
  - Read latency is 1 cycle from the first re cycle.
- Register map:
  - RXDATA (BASE+0): returns the head byte and pops it. If the FIFO is empty, returns 0x00, sets udf, and does not change the pointers.
  - STATUS (BASE+1): {ovf, udf, full, empty, count[3:0]}. Non-destructive. The snapshot is taken before that edge's push/pop.
  - FLAGS (BASE+2): {6'b0, udf, ovf}. Read clears both. A set event on the same edge wins, and that flag stays 1.
  - Any other address returns 0x00 with no side effects.
  - A non-hit PH_ADDR still advances the phase.
- FIFO:
  - Circular buffer with rd/wr pointers of DEPTH_LOG2 bits that wrap modulo DEPTH.
  - count ranges 0..DEPTH; empty = (count==0), full = (count==DEPTH).
- Simultaneous events:
  - Push and pop on a non-empty FIFO: both happen, count unchanged.
  - Push when full with a simultaneous pop: accepted, count stays DEPTH, ovf not set.
  - Push when full with no pop: byte dropped, ovf set.
  - Push into an empty FIFO with a simultaneous RXDATA read: the read returns 0x00 and sets udf; the push completes, count=1.
- Reset (also mid-access):
  - phase=PH_ADDR, inbus_data=0x00, pointers and count = 0, ovf=udf=0.
  - wr_full=0. FIFO memory contents are don't-care.
  - The next access after reset starts a fresh PH_ADDR.

Test Plan:
- Reset, then push 0xA5 and 0x3C; read BASE+1 → 0x02.
  - Read BASE+0 → 0xA5 in the PH_DATA cycle, then read BASE+0 again → 0x3C.
  - Read BASE+1 → 0x10 (empty=1, count=0).
- DEPTH=8: push 9 bytes 0x01..0x09 → wr_full high after the 8th push; the 9th byte is dropped.
  - STATUS → 0xA8. Popping 8 times yields 0x01..0x08. Also exercises wrap-around.
- Read BASE+0 on an empty FIFO → 0x00; STATUS → 0x50.
  - FLAGS → 0x02, then FLAGS again → 0x00.
  - Also cover ovf set on the same edge as a FLAGS read → ovf remains 1.
- Hold inbus_re high for 4 cycles at BASE+0 with 0x11 and 0x22 queued → inbus_data sequence 0x00, 0x11, 0x00, 0x22; exactly 2 pops.
- Full FIFO with a push and RXDATA pop on the same edge → new byte accepted, count stays 8, ovf=0.
  - Read BASE+3 and BASE+0xFF → 0x00, FIFO unchanged.
- Assert reset in the PH_DATA cycle of an RXDATA read → inbus_data 0x00 next cycle; STATUS → 0x10.
  - A subsequent 2-cycle read behaves normally.
